// File: rtl/dbus_result_responder.sv
// Memory-mapped result responder on the CPU data bus: a RESULT register, a push FIFO
// drained into RESULT by a hold-timed FSM, STATUS/CTRL registers and an overflow irq.
module dbus_result_responder #(
   parameter logic [31:0] BASE_ADDR   = 32'h1000_0000,
   parameter int          FIFO_DEPTH  = 8,
   parameter int          HOLD_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        ce,
   input  logic        we,
   input  logic [31:0] addr,
   input  logic [3:0]  sel,
   input  logic [31:0] data_i,
   output logic [31:0] data_o,
   output logic [31:0] result,
   output logic        irq
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int CW = $clog2(FIFO_DEPTH + 1);
   localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

   localparam logic [1:0] OFF_RESULT = 2'd0;
   localparam logic [1:0] OFF_PUSH   = 2'd1;
   localparam logic [1:0] OFF_STATUS = 2'd2;
   localparam logic [1:0] OFF_CTRL   = 2'd3;

   typedef enum logic {ST_IDLE, ST_HOLD} state_t;

   state_t        state_reg;
   logic [HW-1:0] hold_cnt_reg;
   logic [31:0]   result_reg;
   logic [31:0]   fifo_mem [FIFO_DEPTH];
   logic [PW-1:0] rd_ptr_reg;
   logic [PW-1:0] wr_ptr_reg;
   logic [CW-1:0] count_reg;
   logic          ovf_reg;
   logic          drain_en_reg;
   logic          irq_en_reg;

   logic          hit, wr, rd;
   logic [1:0]    off;
   logic          rw0, push_req, fifo_empty, fifo_full;
   logic          pop, push_ok, ovf_set, ovf_clr, ctrl_wr;
   logic [31:0]   head;
   logic [31:0]   result_wr;
   logic [3:0]    count_status;
   logic          unused_addr_bits;

   assign hit = ce && (addr[31:4] == BASE_ADDR[31:4]);
   assign wr  = hit && we;
   assign rd  = hit && !we;
   assign off = addr[3:2];
   assign unused_addr_bits = ^addr[1:0];

   assign rw0      = wr && (off == OFF_RESULT);
   assign push_req = wr && (off == OFF_PUSH) && (sel == 4'hF);
   assign ctrl_wr  = wr && (off == OFF_CTRL) && sel[0];
   assign ovf_clr  = wr && (off == OFF_STATUS) && sel[0] && data_i[2];

   assign fifo_empty   = (count_reg == '0);
   assign fifo_full    = (count_reg == CW'(FIFO_DEPTH));
   assign head         = fifo_mem[rd_ptr_reg];
   assign count_status = 4'(count_reg);

   // A CPU write to RESULT takes priority; the pop simply waits one cycle.
   assign pop     = drain_en_reg && !fifo_empty && !rw0 &&
                    ((state_reg == ST_IDLE) || (hold_cnt_reg == '0));
   assign push_ok = push_req && (!fifo_full || pop);
   assign ovf_set = push_req && fifo_full && !pop;

   generate
      for (genvar gi = 0; gi < 4; gi++) begin : g_byte_wr
         assign result_wr[gi*8 +: 8] = sel[gi] ? data_i[gi*8 +: 8] : result_reg[gi*8 +: 8];
      end
   endgenerate

   always_ff @(posedge clk) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_reg] <= data_i;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= ST_IDLE;
         hold_cnt_reg <= '0;
         result_reg   <= '0;
         rd_ptr_reg   <= '0;
         wr_ptr_reg   <= '0;
         count_reg    <= '0;
         ovf_reg      <= 1'b0;
         drain_en_reg <= 1'b1;
         irq_en_reg   <= 1'b0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + PW'(1);
         end
         if (pop) begin
            rd_ptr_reg <= rd_ptr_reg + PW'(1);
         end
         case ({push_ok, pop})
            2'b10:   count_reg <= count_reg + CW'(1);
            2'b01:   count_reg <= count_reg - CW'(1);
            default: count_reg <= count_reg;
         endcase

         if (ovf_set) begin
            ovf_reg <= 1'b1;
         end else if (ovf_clr) begin
            ovf_reg <= 1'b0;
         end

         if (ctrl_wr) begin
            drain_en_reg <= data_i[0];
            irq_en_reg   <= data_i[1];
         end

         if (rw0) begin
            result_reg <= result_wr;
         end

         case (state_reg)
            ST_IDLE: begin
               if (pop) begin
                  result_reg   <= head;
                  hold_cnt_reg <= HW'(HOLD_CYCLES - 1);
                  state_reg    <= ST_HOLD;
               end
            end
            ST_HOLD: begin
               if (hold_cnt_reg != '0) begin
                  hold_cnt_reg <= hold_cnt_reg - HW'(1);
               end else if (pop) begin
                  result_reg   <= head;
                  hold_cnt_reg <= HW'(HOLD_CYCLES - 1);
               end else begin
                  state_reg <= ST_IDLE;
               end
            end
            default: state_reg <= ST_IDLE;
         endcase
      end
   end

   always_comb begin
      data_o = '0;
      if (rd) begin
         case (off)
            OFF_RESULT: data_o = result_reg;
            OFF_PUSH:   data_o = fifo_empty ? 32'h0 : head;
            OFF_STATUS: data_o = {24'b0, count_status, 1'b0, ovf_reg, fifo_full, fifo_empty};
            OFF_CTRL:   data_o = {30'b0, irq_en_reg, drain_en_reg};
            default:    data_o = '0;
         endcase
      end
   end

   assign result = result_reg;
   assign irq    = irq_en_reg & ovf_reg;

endmodule

// File: tb/tb_dbus_result_responder.sv
// Bench for dbus_result_responder: vector table, directed multi-cycle sequences and
// random bus traffic, all checked each cycle against a queue-based reference model.
module tb_dbus_result_responder;

   localparam logic [31:0] BASE   = 32'h1000_0000;
   localparam int          DEPTH  = 8;
   localparam int          HOLD   = 4;
   localparam logic [31:0] A_RES  = BASE;
   localparam logic [31:0] A_PUSH = BASE + 32'd4;
   localparam logic [31:0] A_STAT = BASE + 32'd8;
   localparam logic [31:0] A_CTRL = BASE + 32'd12;

   logic        clk = 1'b0;
   logic        rst, ce, we, irq;
   logic [31:0] addr, data_i, data_o, result;
   logic [3:0]  sel;

   dbus_result_responder #(
      .BASE_ADDR  (BASE),
      .FIFO_DEPTH (DEPTH),
      .HOLD_CYCLES(HOLD)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .ce    (ce),
      .we    (we),
      .addr  (addr),
      .sel   (sel),
      .data_i(data_i),
      .data_o(data_o),
      .result(result),
      .irq   (irq)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: FIFO as a queue, drain pacing as "edges since last pop".
   logic [31:0] mq[$];
   logic [31:0] m_result = 32'h0;
   bit          m_ovf    = 1'b0;
   bit          m_drain  = 1'b1;
   bit          m_irqen  = 1'b0;
   int          cyc_n    = 0;
   int          last_pop = -1000;

   logic [31:0] obs_do, obs_res;
   logic        obs_irq;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic c, input logic w, input logic [31:0] a);
      logic [31:0] v;
      v = 32'h0;
      if (c && !w && (a[31:4] == BASE[31:4])) begin
         case (a[3:2])
            2'd0: v = m_result;
            2'd1: v = (mq.size() > 0) ? mq[0] : 32'h0;
            2'd2: v = {24'b0, 4'(mq.size()), 1'b0, m_ovf, (mq.size() == DEPTH), (mq.size() == 0)};
            default: v = {30'b0, m_irqen, m_drain};
         endcase
      end
      return v;
   endfunction

   task automatic model_step();
      logic hit, wr, rw0, push_req, pop, ovf_set;
      logic [1:0] off;
      if (rst) begin
         mq.delete();
         m_result = 32'h0;
         m_ovf    = 1'b0;
         m_drain  = 1'b1;
         m_irqen  = 1'b0;
         last_pop = -1000;
      end else begin
         hit      = ce && (addr[31:4] == BASE[31:4]);
         wr       = hit && we;
         off      = addr[3:2];
         rw0      = wr && (off == 2'd0);
         push_req = wr && (off == 2'd1) && (sel == 4'hF);
         pop      = m_drain && (mq.size() > 0) && !rw0 && (cyc_n - last_pop >= HOLD);
         ovf_set  = 1'b0;
         if (pop) begin
            m_result = mq.pop_front();
            last_pop = cyc_n;
         end else if (rw0) begin
            for (int b = 0; b < 4; b++)
               if (sel[b]) m_result[b*8 +: 8] = data_i[b*8 +: 8];
         end
         if (push_req) begin
            if (mq.size() < DEPTH) mq.push_back(data_i);
            else ovf_set = 1'b1;
         end
         if (wr && (off == 2'd3) && sel[0]) begin
            m_drain = data_i[0];
            m_irqen = data_i[1];
         end
         if (ovf_set) m_ovf = 1'b1;
         else if (wr && (off == 2'd2) && sel[0] && data_i[2]) m_ovf = 1'b0;
      end
      cyc_n++;
   endtask

   task automatic cyc(input logic c, input logic w, input logic [31:0] a,
                      input logic [3:0] s, input logic [31:0] d);
      ce = c; we = w; addr = a; sel = s; data_i = d;
      @(negedge clk);
      obs_do  = data_o;
      obs_res = result;
      obs_irq = irq;
      chk("model_data_o", data_o, m_read(c, w, a));
      chk("model_result", result, m_result);
      chk("model_irq", {31'b0, irq}, {31'b0, m_irqen & m_ovf});
      @(posedge clk);
      model_step();
      #1;
   endtask

   task automatic bus_wr(input logic [31:0] a, input logic [3:0] s, input logic [31:0] d);
      cyc(1'b1, 1'b1, a, s, d);
   endtask

   task automatic bus_rd(input logic [31:0] a);
      cyc(1'b1, 1'b0, a, 4'hF, 32'h0);
   endtask

   task automatic idle();
      cyc(1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
   endtask

   typedef struct {
      logic        c;
      logic        w;
      logic [31:0] a;
      logic [3:0]  s;
      logic [31:0] d;
      logic [31:0] exp_do;
      logic [31:0] exp_res;
   } vec_t;

   vec_t tbl [17];

   initial begin
      int n1, n2, first1, first3;
      int off;
      logic [31:0] a;

      tbl[0]  = '{1'b1, 1'b0, A_CTRL, 4'hF, 32'h0,         32'h1,         32'h0};
      tbl[1]  = '{1'b1, 1'b0, A_STAT, 4'hF, 32'h0,         32'h1,         32'h0};
      tbl[2]  = '{1'b1, 1'b1, A_RES,  4'hF, 32'h1122_3344, 32'h0,         32'h0};
      tbl[3]  = '{1'b1, 1'b0, A_RES,  4'hF, 32'h0,         32'h1122_3344, 32'h1122_3344};
      tbl[4]  = '{1'b1, 1'b1, A_RES,  4'h2, 32'h0000_5500, 32'h0,         32'h1122_3344};
      tbl[5]  = '{1'b1, 1'b0, A_RES,  4'hF, 32'h0,         32'h1122_5544, 32'h1122_5544};
      tbl[6]  = '{1'b1, 1'b0, BASE + 32'h10, 4'hF, 32'h0,  32'h0,         32'h1122_5544};
      tbl[7]  = '{1'b1, 1'b1, 32'h2000_0000, 4'hF, 32'hDEAD_BEEF, 32'h0,  32'h1122_5544};
      tbl[8]  = '{1'b0, 1'b1, A_RES,  4'hF, 32'hFFFF_FFFF, 32'h0,         32'h1122_5544};
      tbl[9]  = '{1'b1, 1'b1, A_PUSH, 4'h7, 32'h0000_0077, 32'h0,         32'h1122_5544};
      tbl[10] = '{1'b1, 1'b0, A_STAT, 4'hF, 32'h0,         32'h1,         32'h1122_5544};
      tbl[11] = '{1'b1, 1'b0, A_PUSH, 4'hF, 32'h0,         32'h0,         32'h1122_5544};
      tbl[12] = '{1'b1, 1'b1, A_CTRL, 4'h1, 32'h2,         32'h0,         32'h1122_5544};
      tbl[13] = '{1'b1, 1'b0, A_CTRL, 4'hF, 32'h0,         32'h2,         32'h1122_5544};
      tbl[14] = '{1'b1, 1'b1, A_CTRL, 4'hF, 32'hFFFF_FFFF, 32'h0,         32'h1122_5544};
      tbl[15] = '{1'b1, 1'b0, A_CTRL, 4'hF, 32'h0,         32'h3,         32'h1122_5544};
      tbl[16] = '{1'b1, 1'b1, A_CTRL, 4'hF, 32'h1,         32'h0,         32'h1122_5544};

      rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;

      for (int i = 0; i < 17; i++) begin
         cyc(tbl[i].c, tbl[i].w, tbl[i].a, tbl[i].s, tbl[i].d);
         chk($sformatf("tbl%0d_data_o", i), obs_do, tbl[i].exp_do);
         chk($sformatf("tbl%0d_result", i), obs_res, tbl[i].exp_res);
      end

      // Back-to-back pushes: each value shown for exactly HOLD cycles.
      n1 = 0; n2 = 0; first1 = -1; first3 = -1;
      for (int k = 0; k < 19; k++) begin
         if (k < 3) bus_wr(A_PUSH, 4'hF, 32'hA1 + k);
         else idle();
         if (obs_res == 32'hA1) begin n1++; if (first1 < 0) first1 = k; end
         if (obs_res == 32'hA2) n2++;
         if (obs_res == 32'hA3 && first3 < 0) first3 = k;
      end
      chk("t2_a1_cycles", n1, 4);
      chk("t2_a2_cycles", n2, 4);
      chk("t2_a1_latency", first1, 2);
      chk("t2_a3_start", first3, 10);
      bus_rd(A_STAT);
      chk("t2_status_empty", obs_do, 32'h01);

      // Overflow with drain disabled, irq enable, W1C.
      bus_wr(A_CTRL, 4'hF, 32'h0);
      for (int k = 0; k < 9; k++) bus_wr(A_PUSH, 4'hF, 32'hB0 + k);
      bus_rd(A_STAT);
      chk("t3_status_ovf", obs_do, 32'h86);
      chk("t3_irq_masked", {31'b0, obs_irq}, 32'h0);
      bus_wr(A_CTRL, 4'hF, 32'h2);
      bus_rd(A_CTRL);
      chk("t3_ctrl", obs_do, 32'h2);
      chk("t3_irq_on", {31'b0, obs_irq}, 32'h1);
      bus_wr(A_STAT, 4'h1, 32'h4);
      bus_rd(A_STAT);
      chk("t3_status_w1c", obs_do, 32'h82);
      chk("t3_irq_cleared", {31'b0, obs_irq}, 32'h0);

      // Push into a full FIFO on a pop edge: accepted, no overflow, drains last.
      bus_wr(A_CTRL, 4'hF, 32'h1);
      bus_wr(A_PUSH, 4'hF, 32'hC9);
      bus_rd(A_STAT);
      chk("t4_status_full_no_ovf", obs_do, 32'h82);
      for (int k = 0; k < 40; k++) idle();
      chk("t4_last_value", obs_res, 32'hC9);
      bus_rd(A_STAT);
      chk("t4_status_empty", obs_do, 32'h01);

      // RESULT write on the pop cycle defers the pop by one cycle.
      bus_wr(A_CTRL, 4'hF, 32'h0);
      bus_wr(A_RES, 4'hF, 32'h1122_3344);
      bus_wr(A_PUSH, 4'hF, 32'hD1);
      bus_wr(A_CTRL, 4'hF, 32'h1);
      bus_wr(A_RES, 4'h2, 32'h0000_5500);
      bus_rd(A_RES);
      chk("t5_cpu_write_wins", obs_do, 32'h1122_5544);
      bus_rd(A_RES);
      chk("t5_deferred_pop", obs_do, 32'hD1);

      // Reset in the middle of a drain with ovf and irq active.
      bus_wr(A_CTRL, 4'hF, 32'h0);
      for (int k = 0; k < 9; k++) bus_wr(A_PUSH, 4'hF, 32'hE0 + k);
      bus_wr(A_CTRL, 4'hF, 32'h3);
      idle();
      idle();
      chk("t1_irq_before_rst", {31'b0, obs_irq}, 32'h1);
      rst = 1'b1;
      idle();
      idle();
      rst = 1'b0;
      bus_rd(A_STAT);
      chk("t1_status", obs_do, 32'h01);
      chk("t1_result", obs_res, 32'h0);
      bus_rd(A_CTRL);
      chk("t1_ctrl", obs_do, 32'h1);
      chk("t1_irq", {31'b0, obs_irq}, 32'h0);

      // Random traffic against the model.
      for (int i = 0; i < 1500; i++) begin
         rst = ($urandom_range(0, 199) == 0);
         off = $urandom_range(0, 3);
         if ($urandom_range(0, 19) == 0) a = BASE + 32'h10 + 32'(off * 4);
         else a = BASE + 32'(off * 4) + 32'($urandom_range(0, 3));
         cyc(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)), a,
             ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF, $urandom);
      end
      rst = 1'b0;
      idle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
